// File: rtl/key_debounce_pkg.sv
// -----------------------------------------------------------------------------
// key_debounce_pkg
// Shared types and helpers for the multi-channel key debouncer.
//   hold_state_e : per-channel hold FSM states (released / pressed / held).
//   cnt_w()      : width of a counter that must hold values 0 .. limit-1.
//   max_i()      : integer maximum, used to size the shared hold counter.
// -----------------------------------------------------------------------------
package key_debounce_pkg;

    typedef enum logic [1:0] {
        S_RELEASED = 2'd0,
        S_PRESSED  = 2'd1,
        S_HELD     = 2'd2
    } hold_state_e;

    // A counter that counts 0 .. limit-1 needs $clog2(limit) bits; never
    // return zero so a degenerate limit still yields a legal vector.
    function automatic int cnt_w(input int limit);
        return (limit > 2) ? $clog2(limit) : 1;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// -----------------------------------------------------------------------------
// key_debounce_channel
// One pushbutton channel: 2-flop synchroniser, debounce counter and a hold
// FSM producing press / release / long-press / auto-repeat strobes.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   key_in      in   raw asynchronous key input (polarity per ACTIVE_LOW)
//   key_level   out  debounced level, 1 = pressed
//   key_press   out  1-cycle strobe on accepted press
//   key_release out  1-cycle strobe on accepted release
//   key_long    out  1-cycle strobe after LONG_MAX cycles of continuous press
//   key_repeat  out  1-cycle strobe every REPEAT_MAX cycles after key_long
//
// All outputs are registered and change on the same edge as key_level.
// -----------------------------------------------------------------------------
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int CNT_MAX    = 2_000_000,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_MAX   = 100_000_000,
    parameter int REPEAT_MAX = 20_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam int CNT_W  = cnt_w(CNT_MAX);
    localparam int HOLD_W = cnt_w(max_i(LONG_MAX, REPEAT_MAX));

    // Raw level the key shows when it is not pressed.
    localparam logic REL_LVL = (ACTIVE_LOW != 0);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_MAX - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_MAX - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_MAX - 1);

    logic              sync_p0;
    logic              sync_p1;
    logic              sample;
    logic              differ;
    logic              accept;
    logic              rise;
    logic              fall;
    logic [CNT_W-1:0]  cnt;

    hold_state_e       state;
    hold_state_e       state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic              press_next;
    logic              release_next;
    logic              long_next;
    logic              repeat_next;

    // ---- stage p0/p1: synchroniser, reset to the released raw level ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= REL_LVL;
            sync_p1 <= REL_LVL;
        end else begin
            sync_p0 <= key_in;
            sync_p1 <= sync_p0;
        end
    end

    // Normalised sample: 1 = pressed regardless of board polarity.
    assign sample = sync_p1 ^ REL_LVL;
    assign differ = (sample != key_level);

    // A change is accepted on the edge where the disagreement has been seen
    // for CNT_MAX consecutive samples.
    assign accept = differ && (cnt == CNT_LAST);
    assign rise   = accept && !key_level;
    assign fall   = accept &&  key_level;

    // ---- debounce stage: any agreeing sample restarts the count ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            key_level <= 1'b0;
        end else if (!differ) begin
            cnt       <= '0;
        end else if (accept) begin
            cnt       <= '0;
            key_level <= ~key_level;
        end else begin
            cnt       <= cnt + CNT_W'(1);
        end
    end

    // ---- hold FSM: state register and registered strobes ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RELEASED;
            hold_cnt    <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_next;
            key_press   <= press_next;
            key_release <= release_next;
            key_long    <= long_next;
            key_repeat  <= repeat_next;
        end
    end

    // Release is checked ahead of the state decode so that a release
    // landing on the same edge as a long/repeat expiry suppresses it.
    always_comb begin
        state_next   = state;
        hold_next    = hold_cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;

        if (fall) begin
            state_next   = S_RELEASED;
            hold_next    = '0;
            release_next = 1'b1;
        end else begin
            case (state)
                S_RELEASED: begin
                    hold_next = '0;
                    if (rise) begin
                        state_next = S_PRESSED;
                        press_next = 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (hold_cnt == LONG_LAST) begin
                        state_next = S_HELD;
                        hold_next  = '0;
                        long_next  = 1'b1;
                    end else begin
                        hold_next  = hold_cnt + HOLD_W'(1);
                    end
                end
                S_HELD: begin
                    if (hold_cnt == REP_LAST) begin
                        hold_next   = '0;
                        repeat_next = 1'b1;
                    end else begin
                        hold_next   = hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state_next = S_RELEASED;
                    hold_next  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
// NUM_KEYS independent debounced pushbutton channels for the matrix
// calculator UI. Each bit of every vector belongs to one channel.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   key_in      in   [NUM_KEYS] raw key inputs (polarity per ACTIVE_LOW)
//   key_level   out  [NUM_KEYS] debounced level, 1 = pressed
//   key_press   out  [NUM_KEYS] 1-cycle accepted-press strobes
//   key_release out  [NUM_KEYS] 1-cycle accepted-release strobes
//   key_long    out  [NUM_KEYS] 1-cycle long-press strobes
//   key_repeat  out  [NUM_KEYS] 1-cycle auto-repeat strobes
// -----------------------------------------------------------------------------
module key_debounce_multi
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS   = 4,
    parameter int CNT_MAX    = 2_000_000,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_MAX   = 100_000_000,
    parameter int REPEAT_MAX = 20_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_channel #(
            .CNT_MAX    (CNT_MAX),
            .ACTIVE_LOW (ACTIVE_LOW),
            .LONG_MAX   (LONG_MAX),
            .REPEAT_MAX (REPEAT_MAX)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_in      (key_in[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i]),
            .key_repeat  (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_multi
// Directed bench for key_debounce_multi with NUM_KEYS=4, CNT_MAX=20,
// LONG_MAX=100, REPEAT_MAX=30, ACTIVE_LOW=1 and a 10 ns clock.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. "Edge n" counts rising edges after a raw change, with the
// first edge that samples the new raw value being edge 1.
// -----------------------------------------------------------------------------
module tb_key_debounce_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;
    logic [3:0] key_repeat;

    int checks = 0;
    int errors = 0;

    key_debounce_multi #(
        .NUM_KEYS   (4),
        .CNT_MAX    (20),
        .ACTIVE_LOW (1),
        .LONG_MAX   (100),
        .REPEAT_MAX (30)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        key_in = 4'hF;
        repeat (3) step();
        checks++;
        if (key_level !== 4'b0000) begin errors++; $display("FAIL reset_level got %b want 0000", key_level); end
        checks++;
        if (key_press !== 4'b0000) begin errors++; $display("FAIL reset_press got %b want 0000", key_press); end
        checks++;
        if (key_release !== 4'b0000) begin errors++; $display("FAIL reset_release got %b want 0000", key_release); end
        checks++;
        if (key_long !== 4'b0000) begin errors++; $display("FAIL reset_long got %b want 0000", key_long); end
        checks++;
        if (key_repeat !== 4'b0000) begin errors++; $display("FAIL reset_repeat got %b want 0000", key_repeat); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            checks++;
            if ({key_level, key_press, key_release, key_long, key_repeat} !== 20'h0) begin
                errors++;
                $display("FAIL post_reset_idle edge %0d got lvl=%b prs=%b rel=%b lng=%b rep=%b want all 0",
                         n, key_level, key_press, key_release, key_long, key_repeat);
            end
        end
    endtask

    task automatic test_single_press();
        @(negedge clk);
        key_in[0] = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            step();
            if (n < 22) begin
                checks++;
                if (key_level !== 4'b0000 || key_press !== 4'b0000) begin
                    errors++;
                    $display("FAIL press0_early edge %0d got lvl=%b prs=%b want 0000/0000", n, key_level, key_press);
                end
            end
        end
        checks++;
        if (key_level !== 4'b0001) begin errors++; $display("FAIL press0_level got %b want 0001", key_level); end
        checks++;
        if (key_press !== 4'b0001) begin errors++; $display("FAIL press0_strobe got %b want 0001", key_press); end
        step();
        checks++;
        if (key_press !== 4'b0000 || key_level !== 4'b0001) begin
            errors++;
            $display("FAIL press0_after got prs=%b lvl=%b want 0000/0001", key_press, key_level);
        end
        @(negedge clk);
        key_in[0] = 1'b1;
        for (int n = 1; n <= 23; n++) begin
            step();
            checks++;
            if (key_release !== ((n == 22) ? 4'b0001 : 4'b0000) ||
                key_level   !== ((n >= 22) ? 4'b0000 : 4'b0001)) begin
                errors++;
                $display("FAIL release0 edge %0d got rel=%b lvl=%b", n, key_release, key_level);
            end
        end
    endtask

    task automatic test_bounce();
        int lows[3] = '{5, 12, 19};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            key_in[1] = 1'b0;
            for (int n = 1; n <= lows[k]; n++) step();
            @(negedge clk);
            key_in[1] = 1'b1;
        end
        for (int n = 1; n <= 25; n++) begin
            step();
            checks++;
            if (key_level !== 4'b0000 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
                errors++;
                $display("FAIL bounce_quiet edge %0d got lvl=%b prs=%b rel=%b want 0", n, key_level, key_press, key_release);
            end
        end
        @(negedge clk);
        key_in[1] = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            step();
            checks++;
            if (key_press !== ((n == 22) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL bounce_press edge %0d got %b", n, key_press);
            end
        end
        @(negedge clk);
        key_in[1] = 1'b1;
        for (int n = 1; n <= 22; n++) step();
        checks++;
        if (key_release !== 4'b0010 || key_level !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_release got rel=%b lvl=%b want 0010/0000", key_release, key_level);
        end
    endtask

    task automatic test_long_repeat();
        @(negedge clk);
        key_in[2] = 1'b0;
        for (int n = 1; n <= 22; n++) step();
        checks++;
        if (key_press !== 4'b0100) begin errors++; $display("FAIL long_press got %b want 0100", key_press); end
        for (int n = 1; n <= 195; n++) begin
            step();
            checks++;
            if (key_long !== ((n == 100) ? 4'b0100 : 4'b0000) ||
                key_repeat !== ((n == 130 || n == 160 || n == 190) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL long_repeat edge %0d got lng=%b rep=%b", n, key_long, key_repeat);
            end
        end
        @(negedge clk);
        key_in[2] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            checks++;
            if (key_release !== ((n == 22) ? 4'b0100 : 4'b0000) ||
                key_repeat !== 4'b0000 || key_long !== 4'b0000) begin
                errors++;
                $display("FAIL long_release edge %0d got rel=%b rep=%b lng=%b", n, key_release, key_repeat, key_long);
            end
        end
    endtask

    task automatic test_release_coincident();
        @(negedge clk);
        key_in[1] = 1'b0;
        for (int n = 1; n <= 22; n++) step();
        checks++;
        if (key_press !== 4'b0010) begin errors++; $display("FAIL coinc_press got %b want 0010", key_press); end
        // press at edge P; raw release sampled at P+79 falls key_level at P+100
        for (int n = 1; n <= 78; n++) step();
        @(negedge clk);
        key_in[1] = 1'b1;
        for (int n = 1; n <= 21; n++) step();
        checks++;
        if (key_level !== 4'b0010 || key_long !== 4'b0000) begin
            errors++;
            $display("FAIL coinc_before got lvl=%b lng=%b want 0010/0000", key_level, key_long);
        end
        step();
        checks++;
        if (key_release !== 4'b0010) begin errors++; $display("FAIL coinc_release got %b want 0010", key_release); end
        checks++;
        if (key_long !== 4'b0000) begin errors++; $display("FAIL coinc_long got %b want 0000", key_long); end
        for (int n = 1; n <= 40; n++) begin
            step();
            checks++;
            if (key_long !== 4'b0000 || key_repeat !== 4'b0000 || key_level !== 4'b0000) begin
                errors++;
                $display("FAIL coinc_after edge %0d got lng=%b rep=%b lvl=%b", n, key_long, key_repeat, key_level);
            end
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        for (int n = 1; n <= 22; n++) step();
        checks++;
        if (key_press !== 4'b1001) begin errors++; $display("FAIL simul_press got %b want 1001", key_press); end
        checks++;
        if (key_level !== 4'b1001) begin errors++; $display("FAIL simul_level got %b want 1001", key_level); end
        step();
        checks++;
        if (key_press !== 4'b0000) begin errors++; $display("FAIL simul_press_clear got %b want 0000", key_press); end
        @(negedge clk);
        key_in[3] = 1'b1;
        for (int n = 1; n <= 22; n++) step();
        checks++;
        if (key_release !== 4'b1000) begin errors++; $display("FAIL simul_release3 got %b want 1000", key_release); end
        checks++;
        if (key_level !== 4'b0001) begin errors++; $display("FAIL simul_level0 got %b want 0001", key_level); end
        @(negedge clk);
        key_in[0] = 1'b1;
        for (int n = 1; n <= 22; n++) step();
        checks++;
        if (key_release !== 4'b0001 || key_level !== 4'b0000) begin
            errors++;
            $display("FAIL simul_release0 got rel=%b lvl=%b want 0001/0000", key_release, key_level);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        key_in[2] = 1'b0;
        for (int n = 1; n <= 22; n++) step();
        for (int n = 1; n <= 105; n++) step();
        checks++;
        if (key_level !== 4'b0100) begin errors++; $display("FAIL mid_held_level got %b want 0100", key_level); end
        @(negedge clk);
        key_in[1] = 1'b0;
        for (int n = 1; n <= 12; n++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({key_level, key_press, key_release, key_long, key_repeat} !== 20'h0) begin
            errors++;
            $display("FAIL mid_async_reset got lvl=%b prs=%b rel=%b lng=%b rep=%b want all 0",
                     key_level, key_press, key_release, key_long, key_repeat);
        end
        key_in = 4'hF;
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            checks++;
            if ({key_level, key_press, key_release, key_long, key_repeat} !== 20'h0) begin
                errors++;
                $display("FAIL mid_after_reset edge %0d got lvl=%b prs=%b rel=%b lng=%b rep=%b want all 0",
                         n, key_level, key_press, key_release, key_long, key_repeat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_long_repeat();
        test_release_coincident();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Parametrised multi-channel successor to the single-key debouncer. Each of NUM_KEYS raw pushbutton inputs is synchronised and debounced independently. Each channel produces a clean pressed level plus single-cycle press and release strobes. Each channel also produces long-press and auto-repeat strobes. Sits between board buttons and the matrix-calculator UI/control FSM, replacing per-key debouncer instances.

Parameters:
NUM_KEYS, 4, number of independent key channels (>=1)
CNT_MAX, 2_000_000, stable-sample cycles required to accept a level change (20 ms @ 100 MHz; >=2)
ACTIVE_LOW, 1, 1: raw key reads 0 when pressed; 0: reads 1 when pressed
LONG_MAX, 100_000_000, cycles a debounced press must persist before key_long fires (>CNT_MAX)
REPEAT_MAX, 20_000_000, period in cycles of key_repeat strobes after key_long (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_in  in  NUM_KEYS  raw asynchronous key inputs, polarity per ACTIVE_LOW
key_level  out  NUM_KEYS  debounced level, 1 = pressed (polarity-normalised)
key_press  out  NUM_KEYS  1-cycle strobe on accepted press
key_release  out  NUM_KEYS  1-cycle strobe on accepted release
key_long  out  NUM_KEYS  1-cycle strobe when press held LONG_MAX cycles
key_repeat  out  NUM_KEYS  1-cycle strobe every REPEAT_MAX cycles after key_long while still held

Behaviour:
- Reset (async assert, sync release): synchroniser flops load the released raw level (1 if ACTIVE_LOW, else 0). All counters 0. FSM = S_RELEASED. All outputs 0.
- Sync: 2-flop synchroniser per bit; normalised sample p = sync ^ ACTIVE_LOW, where 1 = pressed.
- Debounce counter, per channel, width $clog2(CNT_MAX):
  - If p == key_level, cnt <= 0.
  - Otherwise cnt increments.
  - When cnt == CNT_MAX-1 and p still differs: key_level flips and cnt <= 0 on that edge.
  - Any single-cycle agreement during counting restarts the count from 0.
- Latency: a clean raw edge appears on key_level exactly 2+CNT_MAX cycles later. Strobes are asserted in the same cycle key_level changes.
- Hold FSM, per channel:
  - S_RELEASED -> S_PRESSED on the key_level 0->1 transition; key_press=1; hold_cnt <= 0.
  - S_PRESSED: hold_cnt increments. At hold_cnt == LONG_MAX-1: key_long=1, go to S_HELD, hold_cnt <= 0.
  - S_HELD: hold_cnt increments. At REPEAT_MAX-1: key_repeat=1, hold_cnt <= 0, wrap.
  - From any state, a key_level 1->0 transition -> S_RELEASED with key_release=1. No long/repeat strobe fires in that cycle; release wins.
- hold_cnt width = $clog2(max(LONG_MAX, REPEAT_MAX)). No counter may overflow or wrap except as defined above.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous strobes.
- Reset mid-count or mid-hold: everything returns to reset values immediately, with no strobe emitted.
- key_press and key_release are never both 1 on one channel in one cycle.

Decomposition:
- Package key_debounce_pkg: hold_state_e enum {S_RELEASED, S_PRESSED, S_HELD}, and a helper function for counter widths.
- Sub-module key_debounce_channel: one channel containing synchroniser, debounce counter and hold FSM, with scalar ports.
- Top-level key_debounce_multi: a generate loop of NUM_KEYS key_debounce_channel instances.

Test Plan (NUM_KEYS=4, CNT_MAX=20, LONG_MAX=100, REPEAT_MAX=30, ACTIVE_LOW=1, 10 ns clk):
- Reset with key_in=4'hF -> all outputs 0. Hold ch0 key_in[0]=0 -> key_level[0]=1 and key_press[0] pulse exactly 22 cycles after the first sampling edge. Other channels stay 0.
- Bounce: toggle key_in[1] with low periods of 5, 12, 19 cycles, then return high -> key_level[1] never changes and no strobes fire. Then hold low 20+ cycles -> press accepted.
- Long/repeat: hold ch2 pressed -> key_long[2] 100 cycles after key_press[2], then key_repeat[2] at +30, +60, +90. Release -> key_release[2] 22 cycles after raw rise and no further repeats.
- Release coincident: raw release timed so key_level falls in the cycle key_long would fire -> only key_release, no key_long.
- Simultaneous: press ch0 and ch3 on the same edge -> key_press=4'b1001 in one cycle. Release ch3 only -> key_release=4'b1000 and ch0 stays pressed.
- Reset mid-operation: assert rst_n=0 while ch1 cnt=10 and ch2 is in S_HELD -> all outputs 0 asynchronously. After deassert with keys released -> no strobes.
